// File: rtl/sc01_pkg.sv
// Shared types and constants for the SC-01 phoneme sequencer.
package sc01_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StLatch,
        StWaitAck,
        StWaitDone
    } sc01_state_e;

    localparam logic [5:0] PH_STOP = 6'd63;

    // Field positions inside a command byte.
    localparam int unsigned PH_LSB    = 0;
    localparam int unsigned PH_MSB    = 5;
    localparam int unsigned PITCH_LSB = 6;
    localparam int unsigned PITCH_MSB = 7;

endpackage

// File: rtl/sc01_cmd_fifo.sv
// Circular command FIFO with wrapping pointers and a separate occupancy counter.
module sc01_cmd_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem[rd_ptr_q];

    // Writes into a full queue and pops from an empty one are ignored.
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/sc01_phoneme_sequencer.sv
// Queues phoneme commands and plays them one at a time into the SC-01 player
// using the LatchCde / AR handshake.
module sc01_phoneme_sequencer #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned LATCH_W     = 2,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   flush,
    input  logic                   AR,
    output logic [5:0]             PhCde,
    output logic [1:0]             Pitch,
    output logic                   LatchCde,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   timeout_err
);

    import sc01_pkg::*;

    localparam int unsigned LAT_CW = $clog2(LATCH_W + 1);
    localparam int unsigned TO_CW  = $clog2(ACK_TIMEOUT + 1);

    sc01_state_e       state_q, state_d;
    logic [LAT_CW-1:0] lat_cnt_q, lat_cnt_d;
    logic [TO_CW-1:0]  to_cnt_q, to_cnt_d;
    logic [5:0]        ph_q, ph_d;
    logic [1:0]        pitch_q, pitch_d;
    logic              latch_q, latch_d;
    logic              ar_seen_q, ar_seen_d;
    logic              terr_q, terr_d;

    logic              pop;
    logic              fifo_empty;
    logic [7:0]        rd_data;

    sc01_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (wr_en),
        .wr_data (wr_data),
        .pop     (pop),
        .flush   (flush),
        .rd_data (rd_data),
        .full    (full),
        .empty   (fifo_empty),
        .level   (level)
    );

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        to_cnt_d  = to_cnt_q;
        ph_d      = ph_q;
        pitch_d   = pitch_q;
        latch_d   = latch_q;
        ar_seen_d = ar_seen_q;
        terr_d    = terr_q;
        pop       = 1'b0;

        case (state_q)
            StIdle: begin
                if (!flush && !fifo_empty && AR) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    pop       = 1'b1;
                    ph_d      = rd_data[PH_MSB:PH_LSB];
                    pitch_d   = rd_data[PITCH_MSB:PITCH_LSB];
                    ar_seen_d = 1'b0;
                    if (rd_data[PH_MSB:PH_LSB] == PH_STOP) begin
                        state_d = StIdle;
                    end else begin
                        state_d   = StLatch;
                        lat_cnt_d = LAT_CW'(LATCH_W);
                    end
                end
            end
            StLatch: begin
                // The first LATCH cycle only arms the registered pulse, so the
                // code has been stable a full cycle before LatchCde rises.
                if (flush) begin
                    state_d = StIdle;
                    latch_d = 1'b0;
                end else begin
                    if (!AR) begin
                        ar_seen_d = 1'b1;
                    end
                    if (lat_cnt_q != '0) begin
                        latch_d   = 1'b1;
                        lat_cnt_d = lat_cnt_q - 1'b1;
                    end else begin
                        latch_d  = 1'b0;
                        state_d  = StWaitAck;
                        to_cnt_d = TO_CW'(ACK_TIMEOUT);
                    end
                end
            end
            StWaitAck: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (!AR || ar_seen_q) begin
                    state_d = StWaitDone;
                end else if (to_cnt_q <= TO_CW'(1)) begin
                    terr_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    to_cnt_d = to_cnt_q - 1'b1;
                end
            end
            StWaitDone: begin
                // Not abortable: the player runs the phoneme to completion.
                if (AR) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush) begin
            terr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            lat_cnt_q <= '0;
            to_cnt_q  <= '0;
            ph_q      <= '0;
            pitch_q   <= '0;
            latch_q   <= 1'b0;
            ar_seen_q <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            to_cnt_q  <= to_cnt_d;
            ph_q      <= ph_d;
            pitch_q   <= pitch_d;
            latch_q   <= latch_d;
            ar_seen_q <= ar_seen_d;
            terr_q    <= terr_d;
        end
    end

    assign PhCde       = ph_q;
    assign Pitch       = pitch_q;
    assign LatchCde    = latch_q;
    assign timeout_err = terr_q;
    assign busy        = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_sc01_phoneme_sequencer.sv
// Scoreboard bench for sc01_phoneme_sequencer with a simple SC-01 player model.
module tb_sc01_phoneme_sequencer;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned LATCH_W = 2;

    logic       clk;
    logic       reset_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       ar;
    logic [5:0] PhCde;
    logic [1:0] Pitch;
    logic       LatchCde;
    logic       full;
    logic [3:0] level;
    logic       busy;
    logic       timeout_err;

    logic       player_on;
    logic       player_ar;
    logic       ar_man;
    int         ar_low;
    logic       skip_w;

    int         vectors;
    int         errors;
    int         pulses;
    logic [7:0] exp_q[$];

    assign ar = player_on ? player_ar : ar_man;

    sc01_phoneme_sequencer #(
        .DEPTH       (DEPTH),
        .LATCH_W     (LATCH_W),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .flush       (flush),
        .AR          (ar),
        .PhCde       (PhCde),
        .Pitch       (Pitch),
        .LatchCde    (LatchCde),
        .full        (full),
        .level       (level),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Back-to-back writes of n consecutive byte values starting at first.
    task automatic burst(input logic [7:0] first, input int n);
        logic [7:0] d;
        d = first;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = d;
            d       = d + 8'd1;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_ar(input logic v, input int budget, input string tag);
        int n;
        n = 0;
        while (ar !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(ar), 32'(v));
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ph"},    32'(PhCde),       32'd0);
        check({tag, "_pitch"}, 32'(Pitch),       32'd0);
        check({tag, "_latch"}, 32'(LatchCde),    32'd0);
        check({tag, "_full"},  32'(full),        32'd0);
        check({tag, "_level"}, 32'(level),       32'd0);
        check({tag, "_busy"},  32'(busy),        32'd0);
        check({tag, "_terr"},  32'(timeout_err), 32'd0);
    endtask

    // Player: drops AR one cycle after seeing the latch rise, holds it ar_low cycles.
    initial begin
        logic lp;
        player_ar = 1'b1;
        lp        = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (player_on && reset_n && LatchCde && !lp) begin
                @(posedge clk);
                #1;
                player_ar = 1'b0;
                repeat (ar_low) @(posedge clk);
                #1;
                player_ar = 1'b1;
                lp        = 1'b0;
            end else begin
                lp = LatchCde;
            end
        end
    end

    // Monitor: every latch pulse consumes one expected command; code held for the pulse.
    initial begin
        logic       lprev;
        int         width;
        logic [7:0] cur;
        lprev = 1'b0;
        width = 0;
        cur   = '0;
        forever begin
            @(negedge clk);
            if (LatchCde === 1'b1) begin
                if (!lprev) begin
                    pulses++;
                    if (exp_q.size() == 0) begin
                        check("pulse_unexpected", {24'd0, Pitch, PhCde}, {24'd0, cur});
                        check("pulse_queue_empty", 32'(exp_q.size()), 32'd1);
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                width++;
                check("latch_code", {24'd0, Pitch, PhCde}, {24'd0, cur});
            end else begin
                if (lprev && !skip_w) begin
                    check("latch_width", 32'(width), 32'(LATCH_W));
                end
                width = 0;
            end
            lprev = (LatchCde === 1'b1);
        end
    end

    initial begin
        int p0;
        int n;
        vectors   = 0;
        errors    = 0;
        pulses    = 0;
        reset_n   = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        flush     = 1'b0;
        ar_man    = 1'b1;
        player_on = 1'b1;
        ar_low    = 100;
        skip_w    = 1'b0;

        // Reset state
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single phoneme: code 5, pitch 2
        p0 = pulses;
        exp_q.push_back(8'h85);
        wr(8'h85);
        wait_ar(1'b0, 20, "single_ar_low");
        wait_ar(1'b1, 200, "single_ar_high");
        check("single_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        check("single_busy_after", 32'(busy), 32'd0);
        check("single_pulses", 32'(pulses - p0), 32'd1);
        check("single_ph_hold", 32'(PhCde), 32'd5);
        check("single_pitch_hold", 32'(Pitch), 32'd2);

        // Queue and overflow: 10 writes into 8 entries with AR low
        player_on = 1'b0;
        ar_man    = 1'b0;
        ar_low    = 8;
        p0        = pulses;
        for (int i = 0; i < 10; i++) begin
            if (i < DEPTH) exp_q.push_back(8'd20 + 8'(i));
        end
        burst(8'd20, 10);
        check("ovf_level", 32'(level), 32'(DEPTH));
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_busy", 32'(busy), 32'd1);
        check("ovf_no_pulse", 32'(pulses - p0), 32'd0);
        player_on = 1'b1;
        wait_idle(2000, "ovf_drain");
        check("ovf_pulses", 32'(pulses - p0), 32'd8);
        check("ovf_sb_empty", 32'(exp_q.size()), 32'd0);
        check("ovf_full_clear", 32'(full), 32'd0);

        // STOP code is consumed silently; next code still plays
        p0 = pulses;
        exp_q.push_back(8'h4A);
        wr(8'h3F);
        wr(8'h4A);
        wait_idle(500, "stop_drain");
        check("stop_pulses", 32'(pulses - p0), 32'd1);
        check("stop_sb_empty", 32'(exp_q.size()), 32'd0);

        // Timeout: AR never drops
        player_on = 1'b0;
        ar_man    = 1'b1;
        p0        = pulses;
        exp_q.push_back(8'hC7);
        exp_q.push_back(8'h09);
        wr(8'hC7);
        wr(8'h09);
        n = 0;
        while (LatchCde !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("to_latch_seen", 32'(LatchCde), 32'd1);
        n = 0;
        while (timeout_err !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("to_cycles", 32'(n), 32'd18);
        check("to_err", 32'(timeout_err), 32'd1);
        wait_idle(200, "to_drain");
        check("to_pulses", 32'(pulses - p0), 32'd2);
        check("to_sb_empty", 32'(exp_q.size()), 32'd0);
        check("to_err_sticky", 32'(timeout_err), 32'd1);

        // Flush during LATCH with 3 entries queued
        skip_w = 1'b1;
        p0     = pulses;
        exp_q.push_back(8'h1E);
        burst(8'h1E, 4);
        n = 0;
        while (LatchCde !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("fl_latch_high", 32'(LatchCde), 32'd1);
        check("fl_level_before", 32'(level), 32'd3);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_latch_drop", 32'(LatchCde), 32'd0);
        check("fl_level", 32'(level), 32'd0);
        check("fl_terr_clear", 32'(timeout_err), 32'd0);
        check("fl_busy", 32'(busy), 32'd0);
        repeat (30) @(negedge clk);
        check("fl_pulses", 32'(pulses - p0), 32'd1);
        check("fl_sb_empty", 32'(exp_q.size()), 32'd0);
        skip_w = 1'b0;

        // Flush during WAIT_DONE: FSM waits for AR regardless
        player_on = 1'b1;
        ar_low    = 40;
        p0        = pulses;
        exp_q.push_back(8'h11);
        burst(8'h11, 2);
        wait_ar(1'b0, 50, "fd_ar_low");
        repeat (3) @(negedge clk);
        check("fd_level_before", 32'(level), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fd_level", 32'(level), 32'd0);
        check("fd_busy_hold", 32'(busy), 32'd1);
        wait_ar(1'b1, 100, "fd_ar_high");
        check("fd_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        check("fd_busy_after", 32'(busy), 32'd0);
        check("fd_pulses", 32'(pulses - p0), 32'd1);

        // Asynchronous reset mid-WAIT_DONE
        ar_low = 100;
        exp_q.push_back(8'h9F);
        wr(8'h9F);
        wait_ar(1'b0, 50, "ar_rst_low");
        repeat (5) @(negedge clk);
        check("pre_rst_ph", 32'(PhCde), 32'd31);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        wait_ar(1'b1, 200, "arst_ar_high");
        @(negedge clk);
        reset_n = 1'b1;
        p0      = pulses;
        exp_q.push_back(8'h23);
        wr(8'h23);
        wait_idle(300, "post_rst_drain");
        check("post_rst_pulses", 32'(pulses - p0), 32'd1);
        check("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);
        check("post_rst_ph", 32'(PhCde), 32'd35);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
